// File: rtl/gameboard_renderer.sv
// Minesweeper board renderer: walks a ROWS x COLS board and emits VGA pixel
// writes, either redrawing every cell or only the cells whose colour changed
// since they were last drawn.
module gameboard_renderer #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int CELL_W = 4,
  parameter int CELL_H = 4,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int X_W    = 8,
  parameter int Y_W    = 7
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [ROWS*COLS-1:0] mineMap,
  input  logic [ROWS*COLS-1:0] flagMap,
  input  logic [ROWS*COLS-1:0] stepMap,
  input  logic                 game_over,
  input  logic                 start,
  input  logic                 full,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [2:0]           color,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PX_W  = $clog2(CELL_W);
  localparam int PY_W  = $clog2(CELL_H);

  typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PX_W-1:0]    px_q, px_d;
  logic [PY_W-1:0]    py_q, py_d;
  logic               wr_cell;

  // Snapshot of the game state taken when a pass starts
  logic [N-1:0]       mine_s, flag_s, step_s;
  logic               go_s, full_s;

  // What was last drawn for each cell
  logic [N-1:0]       valid;
  logic [2:0]         shadow [N];

  logic [2:0]         code;
  logic               need_draw;
  logic               last_cell;

  // Cell colour by priority: revealed mine, revealed, flag, exposed mine, hidden
  function automatic logic [2:0] cell_code(input logic s, input logic m,
                                           input logic f, input logic g);
    if (s && m)      return 3'b100;
    else if (s)      return 3'b111;
    else if (f)      return 3'b110;
    else if (g && m) return 3'b101;
    else             return 3'b001;
  endfunction

  // Right column and bottom row of each cell form the black grid line
  function automatic logic [2:0] pixel_color(input logic [PX_W-1:0] px,
                                             input logic [PY_W-1:0] py,
                                             input logic [2:0] c);
    if (px == PX_W'(CELL_W - 1) || py == PY_W'(CELL_H - 1)) return 3'b000;
    else                                                    return c;
  endfunction

  assign code      = cell_code(step_s[idx_q], mine_s[idx_q], flag_s[idx_q], go_s);
  assign need_draw = full_s || !valid[idx_q] || (shadow[idx_q] != code);
  assign last_cell = (idx_q == IDX_W'(N - 1));

  // Capture the maps and mode at the start of a pass; later map changes are ignored
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      mine_s <= mineMap;
      flag_s <= flagMap;
      step_s <= stepMap;
      go_s   <= game_over;
      full_s <= full;
    end
  end

  // Next-state, cell walk and pixel walk
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    py_d    = py_q;
    wr_cell = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      SCAN, DRAW: begin
        if (state_q == SCAN && need_draw) begin
          state_d = DRAW;
          px_d    = '0;
          py_d    = '0;
        end else if (state_q == DRAW && px_q != PX_W'(CELL_W - 1)) begin
          px_d = px_q + PX_W'(1);
        end else if (state_q == DRAW && py_q != PY_W'(CELL_H - 1)) begin
          px_d = '0;
          py_d = py_q + PY_W'(1);
        end else begin
          // Cell finished (skipped in SCAN or last pixel in DRAW): move on
          wr_cell = (state_q == DRAW);
          if (last_cell) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + IDX_W'(1);
            if (col_q == COL_W'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, registered pixel outputs and per-cell draw history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      x       <= '0;
      y       <= '0;
      color   <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= '0;
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      py_q    <= py_d;
      plot    <= (state_d == DRAW);
      busy    <= (state_d == SCAN) || (state_d == DRAW);
      done    <= (state_d == DONE);
      if (state_d == DRAW) begin
        x     <= X_W'(X0 + int'(col_d) * CELL_W + int'(px_d));
        y     <= Y_W'(Y0 + int'(row_d) * CELL_H + int'(py_d));
        color <= pixel_color(px_d, py_d, code);
      end
      if (wr_cell) begin
        shadow[idx_q] <= code;
        valid[idx_q]  <= 1'b1;
      end
    end
  end

endmodule
